// File: rtl/spio_pkt_demux.sv
// Two-way packet demultiplexer: steers each accepted packet to one or both output links.
// A packet that cannot make progress for DROP_WAIT cycles, or that has an empty mask, is dropped and reported.
module spio_pkt_demux #(
  parameter int PKT_BITS  = 72,
  parameter int DROP_WAIT = 16,
  parameter int CNT_BITS  = 16
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [PKT_BITS-1:0] DATA_IN,
  input  logic [1:0]          DEST_IN,
  input  logic                VLD_IN,
  output logic                RDY_OUT,
  output logic [PKT_BITS-1:0] DATA0_OUT,
  output logic                VLD0_OUT,
  input  logic                RDY0_IN,
  output logic [PKT_BITS-1:0] DATA1_OUT,
  output logic                VLD1_OUT,
  input  logic                RDY1_IN,
  output logic [PKT_BITS-1:0] DROP_DATA_OUT,
  output logic                DROP_VLD_OUT,
  output logic [CNT_BITS-1:0] DROP_CNT_OUT
);

  // Wait counter only ever reaches DROP_WAIT-1, so size it for that.
  localparam int WB = (DROP_WAIT > 1) ? $clog2(DROP_WAIT) : 1;
  localparam logic [WB-1:0] W_LAST = WB'((DROP_WAIT > 0) ? DROP_WAIT - 1 : 0);

  logic                hold_vld_reg;
  logic [PKT_BITS-1:0] hold_data_reg;
  logic [1:0]          hold_mask_reg;
  logic [WB-1:0]       wait_reg;

  logic                drop_vld_reg;
  logic [PKT_BITS-1:0] drop_data_reg;
  logic [CNT_BITS-1:0] drop_cnt_reg;

  logic [1:0]          out_rdy;
  logic [1:0]          out_vld;
  logic [PKT_BITS-1:0] out_data [2];
  logic [1:0]          fwd;
  logic [1:0]          mask_next;
  logic                all_fwd;
  logic                timeout;
  logic                drop;
  logic                freed;
  logic                load;

  assign out_rdy = {RDY1_IN, RDY0_IN};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_out
      logic                vld_reg;
      logic [PKT_BITS-1:0] data_reg;

      assign fwd[gi] = hold_vld_reg && hold_mask_reg[gi] && (!vld_reg || out_rdy[gi]);

      always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
          vld_reg  <= 1'b0;
          data_reg <= '0;
        end else if (fwd[gi]) begin
          vld_reg  <= 1'b1;
          data_reg <= hold_data_reg;
        end else if (out_rdy[gi]) begin
          vld_reg  <= 1'b0;
        end
      end

      assign out_vld[gi]  = vld_reg;
      assign out_data[gi] = data_reg;
    end
  endgenerate

  assign mask_next = hold_mask_reg & ~fwd;
  assign all_fwd   = hold_vld_reg && (hold_mask_reg != 2'b00) && (mask_next == 2'b00);
  assign timeout   = (DROP_WAIT != 0) && (wait_reg == W_LAST);
  // An empty mask can never make progress, so it is dropped without waiting.
  assign drop      = hold_vld_reg && (fwd == 2'b00) && ((hold_mask_reg == 2'b00) || timeout);
  assign freed     = all_fwd || drop;
  assign RDY_OUT   = !hold_vld_reg || freed;
  assign load      = VLD_IN && RDY_OUT;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      hold_vld_reg  <= 1'b0;
      hold_data_reg <= '0;
      hold_mask_reg <= 2'b00;
      wait_reg      <= '0;
    end else if (load) begin
      hold_vld_reg  <= 1'b1;
      hold_data_reg <= DATA_IN;
      hold_mask_reg <= DEST_IN;
      wait_reg      <= '0;
    end else if (freed) begin
      hold_vld_reg  <= 1'b0;
      hold_mask_reg <= 2'b00;
      wait_reg      <= '0;
    end else if (hold_vld_reg) begin
      hold_mask_reg <= mask_next;
      if (fwd != 2'b00)
        wait_reg <= '0;
      else if (DROP_WAIT != 0)
        wait_reg <= wait_reg + WB'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      drop_vld_reg  <= 1'b0;
      drop_data_reg <= '0;
      drop_cnt_reg  <= '0;
    end else begin
      drop_vld_reg <= drop;
      if (drop) begin
        drop_data_reg <= hold_data_reg;
        if (drop_cnt_reg != {CNT_BITS{1'b1}})
          drop_cnt_reg <= drop_cnt_reg + CNT_BITS'(1);
      end
    end
  end

  assign DATA0_OUT     = out_data[0];
  assign VLD0_OUT      = out_vld[0];
  assign DATA1_OUT     = out_data[1];
  assign VLD1_OUT      = out_vld[1];
  assign DROP_DATA_OUT = drop_data_reg;
  assign DROP_VLD_OUT  = drop_vld_reg;
  assign DROP_CNT_OUT  = drop_cnt_reg;

endmodule

// File: doc/spio_pkt_demux.md
Name: spio_pkt_demux

Overview:
- Downstream neighbour of the 2-input round-robin arbiter.
- Consumes the arbiter's merged 72-bit packet stream and steers each packet to one or both of two output links. Steering uses a 2-bit destination mask presented alongside the packet.
- Packets blocked too long by a stalled destination are dropped and reported, so one dead link cannot stall the arbiter and every stream behind it.
- All streams use the vld/rdy handshake: a transfer occurs on a rising edge where VLD and RDY are both high.

Parameters:
- PKT_BITS, 72, packet width in bits.
- DROP_WAIT, 16, cycles a held packet may make no forwarding progress before it is dropped. 0 disables dropping.
- CNT_BITS, 16, width of the saturating drop counter.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset, asynchronous, active-low.
- DATA_IN  in  PKT_BITS  input packet, from the arbiter's DATA_OUT.
- DEST_IN  in  2  destination mask, qualified by VLD_IN. Bit j selects output j.
- VLD_IN  in  1  input valid.
- RDY_OUT  out  1  input ready.
- DATA0_OUT  out  PKT_BITS  output 0 packet.
- VLD0_OUT  out  1  output 0 valid.
- RDY0_IN  in  1  output 0 ready.
- DATA1_OUT  out  PKT_BITS  output 1 packet.
- VLD1_OUT  out  1  output 1 valid.
- RDY1_IN  in  1  output 1 ready.
- DROP_DATA_OUT  out  PKT_BITS  dropped packet.
- DROP_VLD_OUT  out  1  one-cycle drop pulse; no backpressure.
- DROP_CNT_OUT  out  CNT_BITS  saturating count of dropped packets.

Behaviour:
- Reset values: holding register empty, remaining mask 00, wait counter 0. VLD0_OUT=VLD1_OUT=0, DROP_VLD_OUT=0, DROP_CNT_OUT=0, all data outputs 0.
- Reset is asynchronous. Asserting it mid-operation discards held and output packets with no drop report.
- Storage:
  - One holding register: packet, remaining mask R, wait counter W.
  - One output register per link.
- Output register j can accept when !VLDj_OUT or RDYj_IN.
- Forwarding, per cycle with the holding register occupied:
  - For each j with R[j]=1 whose output register can accept, copy the packet into it, set VLDj_OUT=1 and clear R[j].
  - Both bits may be forwarded in the same cycle.
- Output register j with RDYj_IN=1 and no new copy arriving: clears VLDj_OUT. DATAj_OUT holds its value.
- Hold freed when, at this edge, either:
  - all remaining R bits are forwarded, or
  - a drop occurs.
- RDY_OUT = holding empty, or hold freed at this edge. It is combinational from RDYj_IN and state, so back-to-back transfers run at 1 packet/cycle per destination.
- Load on VLD_IN && RDY_OUT: holding := {DATA_IN, DEST_IN}, W := 0.
- Latency: accepted at edge N → VLDj_OUT high after edge N+1 at the earliest (2-stage).
- DEST_IN=00: the packet is accepted and held one cycle. It is then dropped on the next edge regardless of DROP_WAIT: DROP_VLD_OUT pulses and the counter increments.
- Wait counter:
  - W increments on each edge where the hold stays occupied and no R bit was forwarded.
  - W resets to 0 on any partial progress.
- Drop condition: DROP_WAIT≠0 and W==DROP_WAIT-1 and no R bit forwardable this cycle. Then:
  - The hold is freed.
  - For the following cycle, DROP_DATA_OUT=packet and DROP_VLD_OUT=1.
  - DROP_CNT_OUT increments, saturating at all-ones.
- Partial multicast: copies already forwarded stand; only outputs still in R miss the packet.
- DROP_VLD_OUT is high for exactly one cycle per dropped packet. Consecutive drops give consecutive pulses.
- Data-out ordering: per output, packets leave in acceptance order.

Test Plan:
- Unicast streaming: DEST_IN alternates 01/10, RDY0_IN=RDY1_IN=1, 20 packets sequence-tagged 0xA/0xB → each output receives its 10 in order. RDY_OUT is constantly 1 after reset and DROP_CNT_OUT=0.
- Multicast with skew: DEST_IN=11, RDY1_IN=0 for 5 cycles then 1, DROP_WAIT=16:
  - output 0 gets the packet 2 cycles after acceptance;
  - output 1 gets it after its release;
  - no drop, and RDY_OUT is low while R=10.
- Timeout drop: DEST_IN=10, RDY1_IN held 0, DROP_WAIT=4:
  - first packet fills output register 1;
  - second packet is dropped exactly 4 cycles after entering hold;
  - DROP_VLD_OUT pulses with that data and DROP_CNT_OUT=1.
- DROP_WAIT=0, RDY0_IN=0 for 100 cycles → no drop, RDY_OUT low. Releasing RDY0_IN delivers all packets intact.
- DEST_IN=00 packet → accepted, one DROP_VLD_OUT pulse, no VLDx_OUT.
- Saturation and reset: with CNT_BITS=2, 5 drops → DROP_CNT_OUT=3. Asserting reset_i low asynchronously mid-stream → all VLD outputs and the counter are 0 immediately.
